// File: rtl/alu_pipe.sv
// Two-stage pipelined integer ALU with registered flags, carry chaining and
// valid/ready handshakes; results leave in issue order with their tags.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             cin,
  input  logic             use_cf,
  input  logic [TAGW-1:0]  tag_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v,
  output logic [TAGW-1:0]  tag_out
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_MOV = 4'h0;
  localparam logic [3:0] OP_INC = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_ADC = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_SBB = 4'h5;
  localparam logic [3:0] OP_DEC = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_AND = 4'h8;
  localparam logic [3:0] OP_OR  = 4'h9;
  localparam logic [3:0] OP_XOR = 4'hA;
  localparam logic [3:0] OP_SHL = 4'hB;
  localparam logic [3:0] OP_SHR = 4'hC;
  localparam logic [3:0] OP_SAR = 4'hD;
  localparam logic [3:0] OP_ROL = 4'hE;
  localparam logic [3:0] OP_ROR = 4'hF;

  logic             s1Valid_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [TAGW-1:0]  tag_q;
  logic             cin_q, useCf_q;

  logic             outValid_q, z_q, n_q, c_q, v_q, cf_q;
  logic [WIDTH-1:0] y_q;
  logic [TAGW-1:0]  tagOut_q;

  logic adv1, adv2, accept, load2;

  assign adv2     = !outValid_q || out_ready;
  assign adv1     = !s1Valid_q || adv2;
  assign in_ready = adv1;
  assign accept   = in_valid && adv1;
  assign load2    = s1Valid_q && adv2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
    end else begin
      if (adv1) s1Valid_q <= in_valid;
      if (accept) begin
        op_q    <= op;
        a_q     <= a;
        b_q     <= b;
        tag_q   <= tag_in;
        cin_q   <= cin;
        useCf_q <= use_cf;
      end
    end
  end

  // Carry-in is resolved at compute time so a chained op directly behind its
  // predecessor already sees the carry that predecessor just produced.
  logic             k;
  logic [SW-1:0]    s, rotAmt;
  logic [WIDTH-1:0] opB, rot, y_d;
  logic [WIDTH:0]   sum, shl, shr, sar;
  logic             carryIn, c_d, v_d;

  assign k      = useCf_q ? cf_q : cin_q;
  assign s      = b_q[SW-1:0];
  assign rotAmt = (op_q == OP_ROL) ? ({SW{1'b0}} - s) : s;
  assign rot    = WIDTH'({a_q, a_q} >> rotAmt);
  assign shl    = {1'b0, a_q} << s;
  assign shr    = {a_q, 1'b0} >> s;
  assign sar    = $unsigned($signed({a_q, 1'b0}) >>> s);

  always_comb begin
    opB     = b_q;
    carryIn = 1'b0;
    case (op_q)
      OP_INC:  begin opB = '0;   carryIn = 1'b1; end
      OP_ADC:  carryIn = k;
      OP_SUB:  begin opB = ~b_q; carryIn = 1'b1; end
      OP_SBB:  begin opB = ~b_q; carryIn = k;    end
      OP_DEC:  opB = '1;
      default: ;
    endcase
    sum = {1'b0, a_q} + {1'b0, opB} + {{WIDTH{1'b0}}, carryIn};
  end

  // Shift results carry one extra bit that captures the last bit pushed out.
  always_comb begin
    y_d = sum[WIDTH-1:0];
    c_d = 1'b0;
    v_d = 1'b0;
    case (op_q)
      OP_INC, OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_DEC: begin
        c_d = sum[WIDTH];
        v_d = (a_q[WIDTH-1] == opB[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_MOV: y_d = a_q;
      OP_NOT: y_d = ~a_q;
      OP_AND: y_d = a_q & b_q;
      OP_OR:  y_d = a_q | b_q;
      OP_XOR: y_d = a_q ^ b_q;
      OP_SHL: begin y_d = shl[WIDTH-1:0]; c_d = shl[WIDTH]; end
      OP_SHR: begin y_d = shr[WIDTH:1];   c_d = shr[0];     end
      OP_SAR: begin y_d = sar[WIDTH:1];   c_d = sar[0];     end
      OP_ROL: begin y_d = rot; c_d = (s != '0) && rot[0];       end
      OP_ROR: begin y_d = rot; c_d = (s != '0) && rot[WIDTH-1]; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q <= 1'b0;
      y_q        <= '0;
      z_q        <= 1'b0;
      n_q        <= 1'b0;
      c_q        <= 1'b0;
      v_q        <= 1'b0;
      tagOut_q   <= '0;
      cf_q       <= 1'b0;
    end else if (adv2) begin
      outValid_q <= s1Valid_q;
      if (load2) begin
        y_q      <= y_d;
        z_q      <= (y_d == '0);
        n_q      <= y_d[WIDTH-1];
        c_q      <= c_d;
        v_q      <= v_d;
        tagOut_q <= tag_q;
        cf_q     <= c_d;
      end
    end
  end

  assign out_valid = outValid_q;
  assign y         = y_q;
  assign z         = z_q;
  assign n         = n_q;
  assign c         = c_q;
  assign v         = v_q;
  assign tag_out   = tagOut_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: the driver predicts each accepted op with a
// plain-arithmetic model, a separate monitor pops and compares in order.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, cin, use_cf, out_valid, out_ready;
  logic [3:0]  op, tag_in, tag_out;
  logic [31:0] a, b, y;
  logic        z, n, c, v;

  typedef struct packed {
    logic [31:0] y;
    logic        z, n, c, v;
    logic [3:0]  tag;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          fails = 0;
  int          acceptCount = 0;
  logic        modelCf = 1'b0;
  bit          randReady = 0;
  bit          holdValid = 0;
  logic [31:0] holdY;
  logic [3:0]  holdTag;

  alu_pipe #(.WIDTH(32), .TAGW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .cin(cin), .use_cf(use_cf), .tag_in(tag_in), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .z(z), .n(n),
    .c(c), .v(v), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Reference model: plain integer arithmetic on 64-bit values.
  function automatic exp_t refModel(input logic [3:0] o, input logic [31:0] aa,
                                    input logic [31:0] bb, input logic k, input logic [3:0] t);
    exp_t        e;
    longint      ua, ub, sa, sb, full, sfull;
    int          s;
    logic [31:0] r;
    logic        cc, vv;
    ua = longint'(aa);
    ub = longint'(bb);
    sa = longint'($signed(aa));
    sb = longint'($signed(bb));
    s  = int'(bb[4:0]);
    full = 0; sfull = 0; r = '0; cc = 1'b0; vv = 1'b0;
    case (o)
      4'h1: begin full = ua + 1;  sfull = sa + 1;  end
      4'h2: begin full = ua + ub; sfull = sa + sb; end
      4'h3: begin full = ua + ub + longint'(k); sfull = sa + sb + longint'(k); end
      4'h4: begin full = ua - ub; sfull = sa - sb; end
      4'h5: begin full = ua - ub - (1 - longint'(k)); sfull = sa - sb - (1 - longint'(k)); end
      4'h6: begin full = ua - 1;  sfull = sa - 1;  end
      4'h0: r = aa;
      4'h7: r = ~aa;
      4'h8: r = aa & bb;
      4'h9: r = aa | bb;
      4'hA: r = aa ^ bb;
      4'hB: begin r = aa << s; cc = (s != 0) ? aa[32-s] : 1'b0; end
      4'hC: begin r = aa >> s; cc = (s != 0) ? aa[s-1] : 1'b0; end
      4'hD: begin r = 32'($signed(aa) >>> s); cc = (s != 0) ? aa[s-1] : 1'b0; end
      4'hE: begin r = (aa << s) | (aa >> (32 - s)); cc = (s != 0) ? aa[32-s] : 1'b0; end
      default: begin r = (aa >> s) | (aa << (32 - s)); cc = (s != 0) ? aa[s-1] : 1'b0; end
    endcase
    if (o >= 4'h1 && o <= 4'h6) begin
      r  = full[31:0];
      cc = (o <= 4'h3) ? (full > 64'sh0FFFF_FFFF) : (full >= 0);
      vv = (sfull > 64'sd2147483647) || (sfull < -64'sd2147483648);
    end
    e.y = r; e.z = (r == 32'h0); e.n = r[31]; e.c = cc; e.v = vv; e.tag = t;
    return e;
  endfunction

  // Drives one op and holds it until accepted; prediction is made at accept.
  task automatic applyStimulus(input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bb,
                               input logic ci, input logic uc, input logic [3:0] t);
    int   waited = 0;
    bit   done = 0;
    exp_t e;
    @(negedge clk);
    op = o; a = aa; b = bb; cin = ci; use_cf = uc; tag_in = t; in_valid = 1'b1;
    while (!done) begin
      #1;
      if (in_ready) begin
        e = refModel(o, aa, bb, uc ? modelCf : ci, t);
        modelCf = e.c;
        sbq.push_back(e);
        acceptCount++;
        done = 1;
        @(posedge clk);
      end else begin
        waited++;
        if (waited > 60) begin
          checkOutput("accept timeout", 64'(in_ready), 64'd1);
          done = 1;
        end else begin
          @(negedge clk);
        end
      end
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int cyc = 0;
    while ((sbq.size() != 0 || out_valid) && cyc < 300) begin
      @(negedge clk);
      #3;
      cyc++;
    end
    checkOutput("drain empty", 64'(sbq.size()), 64'd0);
  endtask

  // Monitor: compares every transferred result and checks holds during stalls.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst && out_valid) begin
      if (holdValid) begin
        checkOutput("stall hold y", 64'(y), 64'(holdY));
        checkOutput("stall hold tag", 64'(tag_out), 64'(holdTag));
      end
      if (out_ready) begin
        holdValid = 0;
        if (sbq.size() == 0) begin
          checkOutput("unexpected result", 64'(out_valid), 64'd0);
        end else begin
          e = sbq.pop_front();
          checkOutput("result {y,z,n,c,v,tag}", 64'({y, z, n, c, v, tag_out}), 64'(e));
        end
      end else begin
        holdValid = 1;
        holdY     = y;
        holdTag   = tag_out;
      end
    end else begin
      holdValid = 0;
    end
  end

  always @(negedge clk) if (randReady) out_ready = ($urandom_range(0, 3) != 0);

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    logic [31:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    cin = 1'b0; use_cf = 1'b0; tag_in = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset y", 64'(y), 64'd0);
    checkOutput("reset flags zncv", 64'({z, n, c, v}), 64'd0);
    checkOutput("reset tag_out", 64'(tag_out), 64'd0);
    checkOutput("reset in_ready", 64'(in_ready), 64'd1);

    applyStimulus(4'h2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 4'h1);
    applyStimulus(4'h2, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 4'h2);
    applyStimulus(4'h2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 4'h3);
    applyStimulus(4'h3, 32'h0, 32'h0, 1'b0, 1'b1, 4'h4);
    applyStimulus(4'hE, 32'h8000_0001, 32'd1, 1'b0, 1'b0, 4'h5);
    applyStimulus(4'hD, 32'h8000_0001, 32'd4, 1'b0, 1'b0, 4'h6);
    applyStimulus(4'hC, 32'h8000_0001, 32'd32, 1'b0, 1'b0, 4'h7);
    applyStimulus(4'h6, 32'h0, 32'h0, 1'b0, 1'b0, 4'h8);
    applyStimulus(4'h5, 32'h8000_0000, 32'h1, 1'b1, 1'b0, 4'h9);
    waitDrain();

    // Backpressure: two ops fit, the third must wait for the consumer.
    @(negedge clk);
    out_ready = 1'b0;
    base = acceptCount;
    fork
      begin
        applyStimulus(4'h2, 32'd10, 32'd1, 1'b0, 1'b0, 4'h1);
        applyStimulus(4'h4, 32'd10, 32'd3, 1'b0, 1'b0, 4'h2);
        applyStimulus(4'h9, 32'hF0, 32'h0F, 1'b0, 1'b0, 4'h3);
      end
    join_none
    repeat (5) @(negedge clk);
    #3;
    checkOutput("stalled accepts", 64'(acceptCount - base), 64'd2);
    checkOutput("stalled in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    out_ready = 1'b1;
    wait fork;
    waitDrain();

    // Reset with both stages occupied and cf previously set.
    applyStimulus(4'h2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 4'hA);
    waitDrain();
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(4'h2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 4'hB);
    applyStimulus(4'h2, 32'h1, 32'h1, 1'b0, 1'b0, 4'hC);
    @(negedge clk);
    rst = 1'b1;
    sbq.delete();
    modelCf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid-flight reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("mid-flight reset in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    applyStimulus(4'h3, 32'h0, 32'h0, 1'b1, 1'b1, 4'hD);
    @(negedge clk);
    #1;
    checkOutput("latency cycle1 out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    #1;
    checkOutput("latency cycle2 out_valid", 64'(out_valid), 64'd1);
    waitDrain();

    // Random traffic with random consumer backpressure.
    randReady = 1;
    for (int i = 0; i < 300; i++) begin
      ra = $urandom();
      rb = $urandom();
      if ($urandom_range(0, 4) == 0) ra = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
      if ($urandom_range(0, 4) == 0) rb = ($urandom_range(0, 1) != 0) ? 32'h0 : 32'h7FFF_FFFF;
      applyStimulus(4'($urandom_range(0, 15)), ra, rb, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    @(negedge clk);
    randReady = 0;
    out_ready = 1'b1;
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
